start_fifo_srl_ctrl: RTL and testbench
======================================

# start_fifo_srl_ctrl

Control wrapper that turns the shared SRL shift-register primitive into a depth-configurable FIFO for start/done tokens and small payloads between dataflow processes (e.g. the start chain feeding the `PE_i4xi4_pack` array). Owns occupancy tracking, the shift-register write enable and read address, and the full/empty ready-valid handshakes on both sides. One instance sits between each producer/consumer process pair. An optional output register (see Configuration) is available for timing closure.

## Interface
- `DATA_WIDTH`, 1, payload width in bits.
- `ADDR_WIDTH`, 1, read-address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- `DEPTH`, 2, SRL entries; legal range 2..2^ADDR_WIDTH.

- `clk`  in  1  sole clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on `clk`.
- `if_write_ce`  in  1  write-side clock enable; write ignored when 0.
- `if_write`  in  1  producer write request.
- `if_din`  in  DATA_WIDTH  write payload.
- `if_full_n`  out  1  1 = space available.
- `if_read_ce`  in  1  read-side clock enable; read ignored when 0.
- `if_read`  in  1  consumer read request (pop).
- `if_dout`  out  DATA_WIDTH  head-of-FIFO payload (first-word fall-through).
- `if_empty_n`  out  1  1 = `if_dout` valid.

## Operation
- Accepted write: `wr_acc = if_write & if_write_ce & if_full_n`. Accepted read: `rd_acc = if_read & if_read_ce & if_empty_n`.
- Occupancy register `count`, width clog2(DEPTH+1), range 0..DEPTH.
- Shift-register `we = wr_acc`; `din = if_din`; read `addr = (count == 0) ? 0 : count-1`; `if_dout` = shift-register `dout`.
- Update: wr only → count+1; rd only → count-1; both → count unchanged (shift moves the head to index count, address stays count-1, pointing at the next-oldest entry); neither → hold.
- `if_empty_n = (count != 0)`; `if_full_n = (count != DEPTH)`. Both are registered (next-state decode), not combinational from `count`.
- Full: write is blocked even when a read is accepted in the same cycle (no write-through-on-pop).
- Empty: read is ignored; a write into an empty FIFO is not bypassed to `if_dout` in the same cycle.
- Overflow/underflow cannot occur; `count` never wraps.
- Shift-register contents are not reset; `if_dout` is don't-care while `if_empty_n=0`.

## Timing
- Reset: `count=0`, `if_full_n=1`, `if_empty_n=0`; takes effect on the first `clk` edge with `reset=1`. Reset mid-operation discards all entries.
- Write→read latency: write accepted at edge N → `if_empty_n=1`, `if_dout` valid after edge N (visible during cycle N+1).
- Read→next data: pop at edge N → next entry on `if_dout` after edge N; `if_empty_n` falls after edge N if last entry.
- `if_full_n` falls after the edge accepting the DEPTH-th entry; rises after the edge accepting a pop from full.
- Sustained throughput: one write and one read per cycle at any occupancy 1..DEPTH-1.

## Configuration
- `START_FIFO_OREG_EN` defined: adds a registered output stage (`dout_q`, `valid_q`, reset to 0/0). SRL head moves to `dout_q` when `valid_q=0` or a pop is accepted; `if_empty_n=valid_q`; capacity DEPTH+1; write→`if_empty_n` latency 2 cycles; full throughput retained.
- Undefined: combinational `if_dout` from the SRL as described above; capacity DEPTH; latency 1 cycle.

## Structure
- Package `start_fifo_pkg`: count-width function (clog2(DEPTH+1)), DEPTH/ADDR_WIDTH legality check constant, default parameter constants.
- One sub-module: `start_fifo_shiftreg` (SRL storage; ports `clk`, `we`, `addr`, `din`, `dout`; no reset). All handshake/occupancy logic stays in this block.

## Test plan
- Reset with DEPTH=2: after reset `if_full_n=1`, `if_empty_n=0`; assert `reset` with 1 entry held → both outputs return to 1/0 the next cycle.
- Fill/drain DEPTH=4, DATA_WIDTH=8: write 0x11,0x22,0x33,0x44 → `if_full_n=0` after 4th; 5th write 0x55 dropped; reads return 0x11..0x44 in order, then `if_empty_n=0`.
- Simultaneous read/write at count=2 (0xA1,0xA2 held), write 0xA3 with pop → `if_dout` 0xA2, count stays 2; streaming 100 words back-to-back matches a reference queue with zero bubbles.
- Full + read + write same cycle: write blocked, count DEPTH-1, `if_full_n=1` next cycle.
- Clock enables: `if_write=1`, `if_write_ce=0` → no count change; `if_read=1`, `if_read_ce=0` → `if_dout` unchanged.
- With `START_FIFO_OREG_EN`, DEPTH=2: write 0x5 → `if_empty_n=1` 2 cycles later; 3 writes accepted before `if_full_n=0`.

Source files
------------

// File: rtl/start_fifo_pkg.sv
// rtl/start_fifo_pkg.sv - shared constants and helpers for the start-token SRL FIFO
package start_fifo_pkg;

  localparam int START_FIFO_DATA_WIDTH = 1;
  localparam int START_FIFO_ADDR_WIDTH = 1;
  localparam int START_FIFO_DEPTH      = 2;

  // Occupancy runs 0..DEPTH inclusive, hence DEPTH+1 states.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic bit depth_legal(input int depth, input int addr_width);
    return (depth >= 2) && (depth <= (1 << addr_width));
  endfunction

endpackage

// File: rtl/start_fifo_shiftreg.sv
// rtl/start_fifo_shiftreg.sv - SRL storage: shift in at index 0, random-access read
module start_fifo_shiftreg
  import start_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = START_FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = START_FIFO_ADDR_WIDTH,
  parameter int DEPTH      = START_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] sr_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      sr_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  assign dout = sr_q[addr];

endmodule

// File: rtl/start_fifo_srl_ctrl.sv
// rtl/start_fifo_srl_ctrl.sv - occupancy/handshake wrapper turning the SRL into a FWFT FIFO
// Define START_FIFO_OREG_EN to add a registered output stage (capacity DEPTH+1).
module start_fifo_srl_ctrl
  import start_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = START_FIFO_DATA_WIDTH,
  parameter int ADDR_WIDTH = START_FIFO_ADDR_WIDTH,
  parameter int DEPTH      = START_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n
);

  localparam int            CW       = count_width(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  if (!depth_legal(DEPTH, ADDR_WIDTH)) begin : g_bad_cfg
    $error("start_fifo_srl_ctrl: DEPTH must lie in 2..2**ADDR_WIDTH");
  end

  logic [CW-1:0]         count_q, count_d;
  logic                  srl_empty_n_q, srl_empty_n_d;
  logic                  full_n_q, full_n_d;
  logic                  wr_acc;
  logic                  pop;
  logic [ADDR_WIDTH-1:0] sr_addr;
  logic [DATA_WIDTH-1:0] sr_dout;

  assign wr_acc  = if_write & if_write_ce & full_n_q;
  // Oldest entry sits at index count-1; a shift plus pop leaves the next-oldest there.
  assign sr_addr = (count_q == '0) ? '0 : ADDR_WIDTH'(count_q - CW'(1));

  start_fifo_shiftreg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_srl (
    .clk  (clk),
    .we   (wr_acc),
    .addr (sr_addr),
    .din  (if_din),
    .dout (sr_dout)
  );

`ifdef START_FIFO_OREG_EN
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  valid_q, valid_d;
  logic                  rd_acc;

  assign rd_acc = if_read & if_read_ce & valid_q;
  // Refill the output stage whenever it is empty or being drained this cycle.
  assign pop    = srl_empty_n_q & (~valid_q | rd_acc);

  always_comb begin
    valid_d = valid_q;
    dout_d  = dout_q;
    if (pop) begin
      valid_d = 1'b1;
      dout_d  = sr_dout;
    end else if (rd_acc) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      valid_q <= valid_d;
      dout_q  <= dout_d;
    end
  end

  assign if_dout    = dout_q;
  assign if_empty_n = valid_q;
`else
  assign pop        = if_read & if_read_ce & srl_empty_n_q;
  assign if_dout    = sr_dout;
  assign if_empty_n = srl_empty_n_q;
`endif

  always_comb begin
    count_d = count_q;
    if (wr_acc && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!wr_acc && pop) begin
      count_d = count_q - CW'(1);
    end
    srl_empty_n_d = (count_d != '0);
    full_n_d      = (count_d != CNT_FULL);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q       <= '0;
      srl_empty_n_q <= 1'b0;
      full_n_q      <= 1'b1;
    end else begin
      count_q       <= count_d;
      srl_empty_n_q <= srl_empty_n_d;
      full_n_q      <= full_n_d;
    end
  end

  assign if_full_n = full_n_q;

endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// tb/tb_start_fifo_srl_ctrl.sv - vector table, corner sequences and queue-model random checks
module tb_start_fifo_srl_ctrl;

  localparam int DW = 8;
  localparam int AW = 2;
`ifdef START_FIFO_OREG_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 4;
`endif

  logic          clk;
  logic          reset;
  logic          if_write_ce;
  logic          if_write;
  logic [DW-1:0] if_din;
  logic          if_full_n;
  logic          if_read_ce;
  logic          if_read;
  logic [DW-1:0] if_dout;
  logic          if_empty_n;

  int n_vec = 0;
  int n_bad = 0;

  start_fifo_srl_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_write_ce (if_write_ce),
    .if_write    (if_write),
    .if_din      (if_din),
    .if_full_n   (if_full_n),
    .if_read_ce  (if_read_ce),
    .if_read     (if_read),
    .if_dout     (if_dout),
    .if_empty_n  (if_empty_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain queue of stored words; with the output stage, the queue holds
  // the SRL part and (ov, od) holds the registered head.
  logic [DW-1:0] mq[$];
  bit            ov;
  logic [DW-1:0] od;

  function automatic bit m_full_n();
    return mq.size() != DEPTH;
  endfunction

  function automatic bit m_empty_n();
`ifdef START_FIFO_OREG_EN
    return ov;
`else
    return mq.size() != 0;
`endif
  endfunction

  function automatic logic [DW-1:0] m_dout();
`ifdef START_FIFO_OREG_EN
    return od;
`else
    return mq[0];
`endif
  endfunction

  task automatic model_step(input bit rst, input bit wce, input bit wr, input logic [DW-1:0] din,
                            input bit rce, input bit rd);
    bit wa;
    bit ra;
    if (rst) begin
      mq.delete();
      ov = 1'b0;
      od = '0;
    end else begin
      wa = wr && wce && m_full_n();
      ra = rd && rce && m_empty_n();
`ifdef START_FIFO_OREG_EN
      if ((!ov || ra) && mq.size() != 0) begin
        od = mq.pop_front();
        ov = 1'b1;
      end else if (ra) begin
        ov = 1'b0;
      end
`else
      if (ra) void'(mq.pop_front());
`endif
      if (wa) mq.push_back(din);
    end
  endtask

  task automatic check(input string name, input int idx, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic cycle(input bit rst, input bit wce, input bit wr, input logic [DW-1:0] din,
                       input bit rce, input bit rd, input int idx);
    reset       = rst;
    if_write_ce = wce;
    if_write    = wr;
    if_din      = din;
    if_read_ce  = rce;
    if_read     = rd;
    model_step(rst, wce, wr, din, rce, rd);
    @(posedge clk);
    #1;
    check("model_full_n", idx, {7'd0, if_full_n}, {7'd0, m_full_n()});
    check("model_empty_n", idx, {7'd0, if_empty_n}, {7'd0, m_empty_n()});
    if (m_empty_n()) check("model_dout", idx, if_dout, m_dout());
  endtask

  typedef struct {
    bit            rst;
    bit            wce;
    bit            wr;
    logic [DW-1:0] din;
    bit            rce;
    bit            rd;
    bit            ef;
    bit            ee;
    logic [DW-1:0] ed;
  } vec_t;

  initial begin
    vec_t tbl[28];
    int   acc;

    reset = 1'b1; if_write_ce = 1'b0; if_write = 1'b0; if_din = '0;
    if_read_ce = 1'b0; if_read = 1'b0;
    ov = 1'b0; od = '0;
    @(posedge clk);
    #1;

`ifndef START_FIFO_OREG_EN
    //          rst wce wr din    rce rd  full_n empty_n dout
    tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00};
    tbl[1]  = '{0, 1, 1, 8'h11, 0, 0, 1, 1, 8'h11};
    tbl[2]  = '{0, 1, 1, 8'h22, 0, 0, 1, 1, 8'h11};
    tbl[3]  = '{0, 1, 1, 8'h33, 0, 0, 1, 1, 8'h11};
    tbl[4]  = '{0, 1, 1, 8'h44, 0, 0, 0, 1, 8'h11};
    tbl[5]  = '{0, 1, 1, 8'h55, 0, 0, 0, 1, 8'h11};
    tbl[6]  = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h22};
    tbl[7]  = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h33};
    tbl[8]  = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 8'h44};
    tbl[9]  = '{0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00};
    tbl[10] = '{0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00};
    tbl[11] = '{0, 1, 1, 8'hA1, 0, 0, 1, 1, 8'hA1};
    tbl[12] = '{0, 1, 1, 8'hA2, 0, 0, 1, 1, 8'hA1};
    tbl[13] = '{0, 1, 1, 8'hA3, 1, 1, 1, 1, 8'hA2};
    tbl[14] = '{0, 0, 1, 8'hEE, 0, 0, 1, 1, 8'hA2};
    tbl[15] = '{0, 0, 0, 8'h00, 0, 1, 1, 1, 8'hA2};
    tbl[16] = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 8'hA3};
    tbl[17] = '{0, 1, 1, 8'hB0, 1, 1, 1, 1, 8'hB0};
    tbl[18] = '{1, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00};
    tbl[19] = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 8'h00};
    tbl[20] = '{0, 1, 1, 8'hC1, 0, 0, 1, 1, 8'hC1};
    tbl[21] = '{0, 1, 1, 8'hC2, 0, 0, 1, 1, 8'hC1};
    tbl[22] = '{0, 1, 1, 8'hC3, 0, 0, 1, 1, 8'hC1};
    tbl[23] = '{0, 1, 1, 8'hC4, 0, 0, 0, 1, 8'hC1};
    tbl[24] = '{0, 1, 1, 8'hC5, 1, 1, 1, 1, 8'hC2};
    tbl[25] = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 8'hC3};
    tbl[26] = '{0, 0, 0, 8'h00, 1, 1, 1, 1, 8'hC4};
    tbl[27] = '{0, 0, 0, 8'h00, 1, 1, 1, 0, 8'h00};

    for (int i = 0; i < 28; i++) begin
      cycle(tbl[i].rst, tbl[i].wce, tbl[i].wr, tbl[i].din, tbl[i].rce, tbl[i].rd, i);
      check("tbl_full_n", i, {7'd0, if_full_n}, {7'd0, tbl[i].ef});
      check("tbl_empty_n", i, {7'd0, if_empty_n}, {7'd0, tbl[i].ee});
      if (tbl[i].ee) check("tbl_dout", i, if_dout, tbl[i].ed);
    end

    // A write into an empty FIFO must not show up before the clock edge.
    if_write_ce = 1'b1; if_write = 1'b1; if_din = 8'h77;
    #1;
    check("no_bypass", 0, {7'd0, if_empty_n}, 8'd0);
    cycle(0, 1, 1, 8'h77, 0, 0, 0);
    check("no_bypass_after", 0, if_dout, 8'h77);
`else
    cycle(1, 0, 0, 8'h00, 0, 0, 0);
    cycle(0, 1, 1, 8'h05, 0, 0, 1);
    check("oreg_lat1", 0, {7'd0, if_empty_n}, 8'd0);
    cycle(0, 0, 0, 8'h00, 0, 0, 2);
    check("oreg_lat2", 0, {7'd0, if_empty_n}, 8'd1);
    check("oreg_dout", 0, if_dout, 8'h05);
    cycle(1, 0, 0, 8'h00, 0, 0, 3);
    acc = 0;
    for (int i = 0; i < 8 && if_full_n; i++) begin
      acc++;
      cycle(0, 1, 1, DW'(8'h60 + i), 0, 0, 4 + i);
    end
    check("oreg_capacity", 0, DW'(acc), DW'(DEPTH + 1));
`endif

    // Back-to-back streaming: one write and one read every cycle, no bubbles.
    cycle(1, 0, 0, 8'h00, 0, 0, 100);
    cycle(0, 1, 1, DW'($urandom), 0, 0, 101);
    cycle(0, 1, 1, DW'($urandom), 0, 0, 102);
`ifdef START_FIFO_OREG_EN
    cycle(0, 0, 0, 8'h00, 0, 0, 103);
`endif
    for (int i = 0; i < 100; i++) begin
      cycle(0, 1, 1, DW'($urandom), 1, 1, 200 + i);
      check("stream_full_n", i, {7'd0, if_full_n}, 8'd1);
      check("stream_empty_n", i, {7'd0, if_empty_n}, 8'd1);
    end

    // Random traffic with alternating fill-heavy / drain-heavy phases.
    for (int i = 0; i < 800; i++) begin
      bit heavy_wr;
      heavy_wr = ((i / 100) % 2) == 0;
      cycle(($urandom_range(0, 96) == 0),
            ($urandom_range(0, 3) != 0),
            heavy_wr ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
            DW'($urandom),
            ($urandom_range(0, 3) != 0),
            heavy_wr ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            1000 + i);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
